// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: start/done handshake, operands and results of the sequential divider
interface seq_restoring_divider_if #(parameter int WIDTH = 4);
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic div_by_zero;
  modport master(
    output start, dividend, divisor,
    input busy, done, quotient, remainder, div_by_zero
  );
  modport slave(
    input start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] q, d, r;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] quotient, remainder;
  logic div_by_zero;
  logic [WIDTH:0] shifted, trial;
  logic [WIDTH-1:0] q_next, r_next;
  logic accept, last;
  // A kept remainder is always below D, so its top bit is zero and only WIDTH bits are stored
  always_comb begin
    shifted = {r, q[WIDTH-1]};
    trial = shifted - {1'b0, d};
    q_next = {q[WIDTH-2:0], ~trial[WIDTH]};
    r_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    accept = bus.start && (state != CALC);
    last = cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q <= '0;
      d <= '0;
      r <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q <= bus.dividend;
      d <= bus.divisor;
      r <= '0;
      cnt <= '0;
      state <= (bus.divisor == '0) ? DONE : CALC;
      if (bus.divisor == '0) begin
        quotient <= '1;
        remainder <= bus.dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      q <= q_next;
      r <= r_next;
      cnt <= cnt + 1'b1;
      if (last) begin
        state <= DONE;
        quotient <= q_next;
        remainder <= r_next;
        div_by_zero <= 1'b0;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
  assign bus.busy = state == CALC;
  assign bus.done = state == DONE;
  assign bus.quotient = quotient;
  assign bus.remainder = remainder;
  assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scoreboard bench, expected results from integer division
module tb_seq_restoring_divider;
  localparam int W = 4;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic z;
    int e0;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t me;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic last_z = 1'b0;
  seq_restoring_divider_if #(.WIDTH(W)) bus();
  seq_restoring_divider #(.WIDTH(W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t model(int a, int b);
    exp_t e;
    e.z = (b == 0);
    e.q = (b == 0) ? W'((1 << W) - 1) : W'(a / b);
    e.r = (b == 0) ? W'(a) : W'(a % b);
    e.e0 = 0;
    return e;
  endfunction
  task automatic issue(int a, int b);
    exp_t e;
    bus.dividend = W'(a);
    bus.divisor = W'(b);
    bus.start = 1'b1;
    e = model(a, b);
    e.e0 = cyc + 1;
    sb.push_back(e);
  endtask
  task automatic wait_done(output int nb);
    nb = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) return;
      if (bus.busy) nb++;
    end
    checks++;
    errors++;
    $display("FAIL timeout: no done within 40 cycles");
    sb.delete();
  endtask
  task automatic op(int a, int b);
    int nb;
    @(posedge clk) #1 issue(a, b);
    @(posedge clk) #1 bus.start = 1'b0;
    wait_done(nb);
    checks++;
    if (nb != ((b == 0) ? 0 : W)) begin
      errors++;
      $display("FAIL busy_cycles %0d/%0d: got %0d exp %0d", a, b, nb, (b == 0) ? 0 : W);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.busy && bus.done) begin
        errors++;
        $display("FAIL busy_done_overlap at cycle %0d", cyc);
      end
      if (bus.done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          me = sb.pop_front();
          if (bus.quotient !== me.q || bus.remainder !== me.r || bus.div_by_zero !== me.z) begin
            errors++;
            $display("FAIL result: got q=%0d r=%0d z=%0b exp q=%0d r=%0d z=%0b",
              bus.quotient, bus.remainder, bus.div_by_zero, me.q, me.r, me.z);
          end
          checks++;
          if (cyc - me.e0 + 1 != (me.z ? 1 : W + 1)) begin
            errors++;
            $display("FAIL latency: got %0d exp %0d", cyc - me.e0 + 1, me.z ? 1 : W + 1);
          end
          last_q = me.q;
          last_r = me.r;
          last_z = me.z;
        end
      end else if (bus.quotient !== last_q || bus.remainder !== last_r || bus.div_by_zero !== last_z) begin
        errors++;
        $display("FAIL hold: got q=%0d r=%0d z=%0b exp q=%0d r=%0d z=%0b",
          bus.quotient, bus.remainder, bus.div_by_zero, last_q, last_r, last_z);
      end
    end
  end
  initial begin
    int nb;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #12;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b done=%0b q=%0d r=%0d z=%0b exp all 0",
        bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk) #3 rst_n = 1'b1;
    op(13, 3);
    op(15, 1);
    op(2, 9);
    op(15, 15);
    op(0, 7);
    op(5, 0);
    op(6, 2);
    // a start pulse mid-calculation must not launch a second division
    @(posedge clk) #1 issue(13, 2);
    @(posedge clk) #1 bus.start = 1'b0;
    @(posedge clk) #1 begin bus.start = 1'b1; bus.dividend = 4'd3; bus.divisor = 4'd1; end
    @(posedge clk) #1 bus.start = 1'b0;
    wait_done(nb);
    repeat (8) @(negedge clk);
    @(posedge clk) #1 issue(11, 3);
    @(posedge clk) #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    last_q = '0;
    last_r = '0;
    last_z = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL mid_calc_reset: got busy=%0b done=%0b q=%0d r=%0d z=%0b exp all 0",
        bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    op(9, 4);
    @(posedge clk) #1 issue(7, 2);
    wait_done(nb);
    issue(14, 5);
    wait_done(nb);
    bus.start = 1'b0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op(a, b);
    repeat (30) op(int'($urandom_range(15)), int'($urandom_range(15)));
    @(posedge clk) #1 issue(int'($urandom_range(15)), int'($urandom_range(1, 15)));
    for (int k = 0; k < 10; k++) begin
      wait_done(nb);
      issue(int'($urandom_range(15)), int'($urandom_range(15)));
    end
    wait_done(nb);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
